// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the helper that sizes the bit counter.
package serial_subtractor_pkg;

    // Two-bit encoding; the fourth code is unreachable and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter has to hold 0..WIDTH, so WIDTH+1 distinct values.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor. This is the only arithmetic in the serial
// subtractor: a single instance is reused for every bit position, one bit
// per clock.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and outgoing borrow for a - b - bin.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, diff = a - b mod 2^WIDTH, LSB first.
// Handshake: the operand pair is accepted in IDLE, WIDTH RUN cycles follow,
// and the result is held in DONE until out_ready.
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the ovf output,
// which flags two's-complement overflow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    // Stop elaboration if WIDTH is outside the range the design supports.
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
        $error("serial_subtractor: WIDTH must be in 2..32");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bin_q, bin_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fs_d;
    logic             fs_bout;
    logic             last_bit;

    // The operand shift registers present the current bit at position 0.
    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bin_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // cnt_q counts the bits already processed, so bit WIDTH-1 is the last.
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // State and datapath registers. Reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            bin_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, shift one bit per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The result fills from the MSB end. After WIDTH shifts, the
                // first bit computed has reached bit 0.
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {fs_d, res_q[WIDTH-1:1]};
                bin_d = fs_bout;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The datapath is frozen here, so diff and bout stay stable
                // while the consumer stalls.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and result outputs come straight from the registers.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
        diff      = res_q;
        bout      = bin_q;
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_sgn_q, b_sgn_q;

    // The sign bits are shifted out of the operand registers during RUN, so a
    // separate copy is kept for the overflow check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sgn_q <= 1'b0;
            b_sgn_q <= 1'b0;
        end else if (in_valid && state_q == IDLE) begin
            a_sgn_q <= a[WIDTH-1];
            b_sgn_q <= b[WIDTH-1];
        end
    end

    // Overflow happens when the operand signs differ and the result sign
    // differs from the minuend sign. It is only reported together with out_valid.
    always_comb begin
        ovf = out_valid && (a_sgn_q != b_sgn_q) && (res_q[WIDTH-1] != a_sgn_q);
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor. A WIDTH=8 and a WIDTH=4
// instance share the stimulus, and use8 selects which one is being exercised.
// Expected values come from plain integer arithmetic on the operands.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       use8;
    logic [7:0] a;
    logic [7:0] b;

    logic       iv8, or8, ir8, ov8, bo8, bz8;
    logic       iv4, or4, ir4, ov4, bo4, bz4;
    logic [7:0] diff8;
    logic [3:0] diff4;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic       ovf8, ovf4;
`endif

    int checks   = 0;
    int failures = 0;

    assign iv8 = in_valid & use8;
    assign or8 = out_ready & use8;
    assign iv4 = in_valid & ~use8;
    assign or4 = out_ready & ~use8;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a), .b(b), .out_valid(ov8), .out_ready(or8),
        .diff(diff8), .bout(bo8),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .ovf(ovf8),
`endif
        .busy(bz8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a[3:0]), .b(b[3:0]), .out_valid(ov4), .out_ready(or4),
        .diff(diff4), .bout(bo4),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .ovf(ovf4),
`endif
        .busy(bz4)
    );

    // Outputs of whichever instance is currently selected.
    logic       o_ir, o_ov, o_bo, o_bz;
    logic [7:0] o_diff;
    assign o_ir   = use8 ? ir8 : ir4;
    assign o_ov   = use8 ? ov8 : ov4;
    assign o_bo   = use8 ? bo8 : bo4;
    assign o_bz   = use8 ? bz8 : bz4;
    assign o_diff = use8 ? diff8 : {4'b0, diff4};
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic o_ovf;
    assign o_ovf = use8 ? ovf8 : ovf4;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: unsigned difference modulo 2^w, borrow on a < b, and
    // signed overflow when the exact signed difference is out of range.
    function automatic logic [31:0] m_diff(input int w, input int av, input int bv);
        return 32'((av - bv) & ((1 << w) - 1));
    endfunction

    function automatic logic [31:0] m_bout(input int av, input int bv);
        return (av < bv) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] m_ovf(input int w, input int av, input int bv);
        int half, sa, sb, sd;
        half = 1 << (w - 1);
        sa   = (av >= half) ? av - (1 << w) : av;
        sb   = (bv >= half) ? bv - (1 << w) : bv;
        sd   = sa - sb;
        return (sd >= half || sd < -half) ? 32'd1 : 32'd0;
    endfunction

    // One full transaction. The bench sits just after a posedge, or at a
    // negedge, when this is called. During RUN and DONE, in_valid and
    // out_ready are toggled to confirm that they are ignored, and the operands
    // are scrambled after acceptance.
    task automatic txn(input int av, input int bv, input int stall, input bit noise);
        int w;
        logic [31:0] ed, eb;
        w  = use8 ? 8 : 4;
        ed = m_diff(w, av, bv);
        eb = m_bout(av, bv);
        chk("idle_in_ready", 32'(o_ir), 32'd1);
        chk("idle_busy", 32'(o_bz), 32'd0);
        a         = 8'(av);
        b         = 8'(bv);
        in_valid  = 1'b1;
        out_ready = noise ? 1'($urandom) : 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        chk("run_busy", 32'(o_bz), 32'd1);
        chk("run_in_ready", 32'(o_ir), 32'd0);
        for (int k = 1; k < w; k++) begin
            if (noise) begin
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
            end
            @(posedge clk); #1;
            chk("run_no_valid", 32'(o_ov), 32'd0);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        chk("done_valid", 32'(o_ov), 32'd1);
        chk("done_diff", 32'(o_diff), ed);
        chk("done_bout", 32'(o_bo), eb);
        chk("done_in_ready", 32'(o_ir), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("done_ovf", 32'(o_ovf), m_ovf(w, av, bv));
`endif
        for (int s = 0; s < stall; s++) begin
            in_valid = noise ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
            chk("stall_valid", 32'(o_ov), 32'd1);
            chk("stall_diff", 32'(o_diff), ed);
            chk("stall_bout", 32'(o_bo), eb);
            chk("stall_in_ready", 32'(o_ir), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ret_valid", 32'(o_ov), 32'd0);
        chk("ret_in_ready", 32'(o_ir), 32'd1);
        chk("ret_busy", 32'(o_bz), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        use8      = 1'b1;
        a         = '0;
        b         = '0;
        #2;
        // Reset values are checked before any clock edge, on both instances.
        for (int u = 0; u < 2; u++) begin
            use8 = 1'(u);
            #1;
            chk("rst_in_ready", 32'(o_ir), 32'd1);
            chk("rst_out_valid", 32'(o_ov), 32'd0);
            chk("rst_busy", 32'(o_bz), 32'd0);
            chk("rst_diff", 32'(o_diff), 32'd0);
            chk("rst_bout", 32'(o_bo), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            chk("rst_ovf", 32'(o_ovf), 32'd0);
`endif
        end
        use8 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // The first acceptance happens on the first edge after reset release.
        txn(5, 3, 0, 1'b0);
        txn(3, 5, 1, 1'b1);
        txn(0, 0, 0, 1'b1);
        txn(8'h80, 8'h01, 0, 1'b0);
        txn(8'h10, 8'h01, 0, 1'b0);
        txn(8'hAA, 8'hAA, 0, 1'b1);
        txn(0, 8'hFF, 0, 1'b1);
        txn(8'hFF, 0, 0, 1'b1);
        txn(8'h7F, 8'h80, 0, 1'b0);
        // Hold DONE for five cycles with in_valid pulsing.
        txn(8'h3C, 8'hC3, 5, 1'b1);
        for (int i = 0; i < 20; i++) begin
            txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 3)), 1'b1);
        end

        // Assert reset while the fifth bit is in flight, then release it.
        a        = 8'h5A;
        b        = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(o_ir), 32'd1);
        chk("midrst_out_valid", 32'(o_ov), 32'd0);
        chk("midrst_busy", 32'(o_bz), 32'd0);
        chk("midrst_diff", 32'(o_diff), 32'd0);
        chk("midrst_bout", 32'(o_bo), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            chk("postrst_no_valid", 32'(o_ov), 32'd0);
            chk("postrst_busy", 32'(o_bz), 32'd0);
        end
        txn(8'hFF, 8'hFF, 0, 1'b0);

        // All 256 operand pairs on the 4-bit instance, with random stalls.
        use8 = 1'b0;
        #1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                txn(x, y, int'($urandom_range(0, 3)), 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
